key_detector: RTL and testbench

KEY_DETECTOR -- requirements
Module: key_detector

---
 rtl/key_detector.sv | 145 ++++++++++++++
 tb/tb_key_detector.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/key_detector.sv
// Purpose: scans a band of rows in the camera frame buffer and flags each piano key whose strip holds enough dark pixels.
// Latency: first address one cycle after start is sampled; done (with fresh keys) N+1 cycles after that, N = pixels in the band.
// Backpressure: none; start is honoured only in IDLE, and requests arriving while busy are dropped, not queued.
module key_detector #(
  parameter int IMG_W     = 320,
  parameter int ROW_START = 200,
  parameter int ROW_END   = 239,
  parameter int KEY_W     = 40,
  parameter int DARK_LVL  = 6,
  parameter int COUNT_MIN = 800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [31:0] addr,
  input  logic [8:0]  q,
  output logic        busy,
  output logic        done,
  output logic [7:0]  keys
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DECIDE} state_t;

  localparam logic [15:0] X_LAST  = 16'(IMG_W - 1);
  localparam logic [15:0] Y_FIRST = 16'(ROW_START);
  localparam logic [15:0] Y_LAST  = 16'(ROW_END);
  localparam logic [31:0] ROW_PIX = 32'(IMG_W);
  localparam logic [4:0]  DARK5   = 5'(DARK_LVL);
  localparam logic [15:0] CMIN    = 16'(COUNT_MIN);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] x;
  logic [15:0] y;
  logic [15:0] col_p;
  logic        pix_vld;
  logic [15:0] cnt [8];
  logic [7:0]  keys_r;
  logic [7:0]  keys_cmp;
  logic [2:0]  key_idx;
  logic        key_hit;
  logic [4:0]  sum;
  logic        dark;
  logic        accept;
  logic        last_pix;

  assign accept   = (state == IDLE) && start;
  assign last_pix = (x == X_LAST) && (y == Y_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: DRAIN gives the last issued pixel one cycle to return.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SCAN;
      SCAN:    if (last_pix) state_nxt = DRAIN;
      DRAIN:   state_nxt = DECIDE;
      DECIDE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: address only while scanning, keys show the fresh decision during DECIDE.
  always_comb begin
    busy = (state != IDLE);
    done = (state == DECIDE);
    addr = 32'd0;
    if (state == SCAN) addr = {16'd0, y} * ROW_PIX + {16'd0, x};
    keys = (state == DECIDE) ? keys_cmp : keys_r;
  end

  // Raster position within the scanned band.
  always_ff @(posedge clk) begin
    if (rst) begin
      x <= 16'd0;
      y <= 16'd0;
    end else if (accept) begin
      x <= 16'd0;
      y <= Y_FIRST;
    end else if (state == SCAN) begin
      if (x == X_LAST) begin
        x <= 16'd0;
        y <= y + 16'd1;
      end else begin
        x <= x + 16'd1;
      end
    end
  end

  // Column of the address issued last cycle, aligned with the q it produces.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_p   <= 16'd0;
      pix_vld <= 1'b0;
    end else begin
      col_p   <= x;
      pix_vld <= (state == SCAN);
    end
  end

  // Map the delayed column onto a key strip; columns past the last key hit nothing.
  always_comb begin
    key_idx = 3'd0;
    key_hit = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (col_p >= 16'(k * KEY_W) && col_p < 16'((k + 1) * KEY_W)) begin
        key_idx = 3'(k);
        key_hit = 1'b1;
      end
    end
  end

  // Dark test on the returned pixel.
  always_comb begin
    sum  = {2'b00, q[8:6]} + {2'b00, q[5:3]} + {2'b00, q[2:0]};
    dark = (sum < DARK5);
  end

  // Per-key saturating dark-pixel counters, cleared when a scan is accepted.
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      for (int k = 0; k < 8; k++) cnt[k] <= 16'd0;
    end else if (pix_vld && key_hit && dark && (cnt[key_idx] != 16'hFFFF)) begin
      cnt[key_idx] <= cnt[key_idx] + 16'd1;
    end
  end

  // Threshold compare of every counter at once.
  always_comb begin
    keys_cmp = 8'd0;
    for (int k = 0; k < 8; k++) keys_cmp[k] = (cnt[k] >= CMIN);
  end

  // Held key bitmap, refreshed only at the end of DECIDE.
  always_ff @(posedge clk) begin
    if (rst)                  keys_r <= 8'd0;
    else if (state == DECIDE) keys_r <= keys_cmp;
  end

endmodule

// File: tb/tb_key_detector.sv
module tb_key_detector;

  localparam int W  = 320;
  localparam int R0 = 200;
  localparam int R1 = 239;
  localparam int N  = W * (R1 - R0 + 1);

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] addr;
  logic [8:0]  q;
  logic        busy;
  logic        done;
  logic [7:0]  keys;

  logic [8:0]  mem [0:76799];

  int          n_tests = 0;
  int          n_fail  = 0;

  int          done_cyc, ndone, busy_rise, busy_cnt, keys_moved;
  logic        busy_after;
  logic [7:0]  keys_at_done;
  logic [31:0] addr_drain;
  int          addr_q[$];

  key_detector dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .addr (addr),
    .q    (q),
    .busy (busy),
    .done (done),
    .keys (keys)
  );

  always #5 clk = ~clk;

  // Frame memory with one-cycle read latency.
  always @(posedge clk) q <= (addr < 32'd76800) ? mem[addr[16:0]] : 9'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: count dark pixels per key strip straight from the frame contents.
  function automatic logic [7:0] model_keys();
    int cnt[8];
    int s;
    logic [8:0] px;
    logic [7:0] r;
    for (int k = 0; k < 8; k++) cnt[k] = 0;
    for (int yy = R0; yy <= R1; yy++)
      for (int xx = 0; xx < W; xx++) begin
        px = mem[yy * W + xx];
        s  = int'(px[8:6]) + int'(px[5:3]) + int'(px[2:0]);
        if (s < 6 && xx / 40 < 8) cnt[xx / 40]++;
      end
    r = 8'd0;
    for (int k = 0; k < 8; k++) r[k] = (cnt[k] >= 800);
    return r;
  endfunction

  task automatic fill_const(input logic [8:0] v);
    for (int i = 0; i < 76800; i++) mem[i] = v;
  endtask

  // Put exactly n pixels of value v into a key strip (raster order), white elsewhere in it.
  task automatic fill_strip(input int k, input int n, input logic [8:0] v);
    int c;
    c = 0;
    for (int yy = R0; yy <= R1; yy++)
      for (int xx = k * 40; xx < k * 40 + 40; xx++) begin
        mem[yy * W + xx] = (c < n) ? v : 9'h1FF;
        c++;
      end
  endtask

  // Random frame with a per-key dark density chosen to straddle the threshold.
  task automatic fill_random();
    int p[8];
    for (int k = 0; k < 8; k++) p[k] = $urandom_range(30, 70);
    for (int yy = R0; yy <= R1; yy++)
      for (int xx = 0; xx < W; xx++) begin
        if (($urandom % 100) < p[xx / 40])
          mem[yy * W + xx] = {3'($urandom % 3), 3'($urandom % 3), 3'($urandom % 3)};
        else
          mem[yy * W + xx] = 9'($urandom);
      end
  endtask

  // Issue start at this negedge and watch N+3 cycles; cycle 1 is the first cycle after start is sampled.
  task automatic run_scan(input int repulse_at);
    logic [7:0] keys_before;
    keys_before = keys;
    ndone = 0; done_cyc = -1; busy_rise = -1; busy_cnt = 0; keys_moved = 0;
    addr_drain = 32'hDEAD_BEEF;
    addr_q.delete();
    start = 1'b1;
    for (int cyc = 1; cyc <= N + 3; cyc++) begin
      @(negedge clk);
      if (busy) begin
        busy_cnt++;
        if (busy_rise < 0) busy_rise = cyc;
      end
      if (cyc <= N) addr_q.push_back(int'(addr));
      if (cyc == N + 1) addr_drain = addr;
      if (done) begin
        ndone++;
        done_cyc = cyc;
        keys_at_done = keys;
      end else if (cyc < N + 2 && keys !== keys_before) begin
        keys_moved++;
      end
      if (cyc == N + 3) busy_after = busy;
      start = (cyc == repulse_at);
    end
    start = 1'b0;
  endtask

  initial begin
    int seq_err;
    int nd;
    logic [7:0] exp_k;
    logic       busy_seen;

    rst = 1'b1;
    start = 1'b0;
    fill_const(9'h1FF);
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_keys", keys, 0);
    check("reset_addr", addr, 0);
    start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset_busy", busy, 0);

    // White frame with a stray start at cycle 100.
    run_scan(100);
    check("white_done_cycle", done_cyc, 12802);
    check("white_done_count", ndone, 1);
    check("white_busy_rise", busy_rise, 1);
    check("white_busy_span", done_cyc - busy_rise, 12801);
    check("white_busy_contig", busy_cnt, done_cyc - busy_rise + 1);
    check("white_busy_after", busy_after, 0);
    check("white_keys", keys_at_done, 8'h00);
    check("white_keys_model", keys_at_done, model_keys());
    check("addr_count", addr_q.size(), N);
    check("addr_first", addr_q[0], 64000);
    check("addr_second", addr_q[1], 64001);
    check("addr_row_end", addr_q[319], 64319);
    check("addr_row_next", addr_q[320], 64320);
    check("addr_last", addr_q[N - 1], 76799);
    seq_err = 0;
    foreach (addr_q[i]) if (addr_q[i] != 64000 + i) seq_err++;
    check("addr_sequence", seq_err, 0);
    check("addr_drain_zero", addr_drain, 0);

    // Dark strips on keys 1 and 7, exact-threshold key 3, sum-5 key 0, sum-6 key 2.
    fill_const(9'h1FF);
    fill_strip(1, 1600, 9'h000);
    fill_strip(7, 1600, 9'h000);
    fill_strip(3, 800, 9'h000);
    fill_strip(0, 800, 9'b000_000_101);
    fill_strip(2, 1600, 9'b000_000_110);
    exp_k = model_keys();
    run_scan(N + 2);
    check("patB_keys_const", keys_at_done, 8'b1000_1011);
    check("patB_keys_model", keys_at_done, exp_k);
    check("patB_keys_stable", keys_moved, 0);
    check("patB_keys_hold", keys, exp_k);
    check("start_in_decide_ignored", busy_after, 0);

    // Random frame with key 3 and key 0 one pixel short of the threshold; started in first IDLE cycle.
    fill_random();
    fill_strip(3, 799, 9'h000);
    fill_strip(0, 799, 9'b000_000_101);
    exp_k = model_keys();
    run_scan(0);
    check("restart_first_idle", busy_rise, 1);
    check("patC_done_cycle", done_cyc, 12802);
    check("patC_key3_below", keys_at_done[3], 0);
    check("patC_key0_below", keys_at_done[0], 0);
    check("patC_keys_model", keys_at_done, exp_k);

    // Fully random frame.
    fill_random();
    exp_k = model_keys();
    run_scan(0);
    check("patD_keys_model", keys_at_done, exp_k);
    check("patD_done_count", ndone, 1);
    check("patD_keys_hold", keys, exp_k);

    // Reset at cycle 5000 of a scan aborts it.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_seen = 1'b1;
    for (int c = 2; c <= 5000; c++) begin
      @(negedge clk);
      if (!busy) busy_seen = 1'b0;
    end
    check("abort_busy_before", busy_seen, 1);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_keys", keys, 0);
    check("abort_done", done, 0);
    check("abort_addr", addr, 0);
    nd = 0;
    busy_seen = 1'b0;
    for (int c = 0; c < 9000; c++) begin
      @(negedge clk);
      if (done) nd++;
      if (busy) busy_seen = 1'b1;
    end
    check("abort_no_done", nd, 0);
    check("abort_stays_idle", busy_seen, 0);
    check("abort_keys_later", keys, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
